// File: rtl/serial_loader_if.sv
// Handshake bundle between a serial bit source and the loader.
// The master drives frames; the slave (loader) returns the word and strobes.
interface serial_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sl_start;
    logic                  sl_bit_valid;
    logic                  sl_bit;
    logic [DATA_WIDTH-1:0] sl_out;
    logic                  sl_wr;
    logic                  sl_busy;
    logic                  sl_error;

    modport master (
        output sl_start,
        output sl_bit_valid,
        output sl_bit,
        input  sl_out,
        input  sl_wr,
        input  sl_busy,
        input  sl_error
    );

    modport slave (
        input  sl_start,
        input  sl_bit_valid,
        input  sl_bit,
        output sl_out,
        output sl_wr,
        output sl_busy,
        output sl_error
    );
endinterface

// File: rtl/serial_loader.sv
// MSB-first serial word loader with trailing even-parity check.
// Emits a one-cycle write strobe on a good frame, an error pulse otherwise.
module serial_loader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic            clock,
    input  logic            sl_reset,
    serial_loader_if.slave  bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        WRITE
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  wr_q;
    logic                  busy_q;
    logic                  err_q;
    logic                  par_ok;

    assign shreg_d = {shreg_q[DATA_WIDTH-2:0], bus.sl_bit};
    assign par_ok  = (bus.sl_bit == ^shreg_q);

    always_ff @(posedge clock) begin
        if (sl_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.sl_start) begin
                        cnt_q   <= '0;
                        shreg_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A restart outranks the bit presented in the same cycle
                    if (bus.sl_start) begin
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end else if (bus.sl_bit_valid) begin
                        shreg_q <= shreg_d;
                        if (cnt_q == LAST) begin
                            state_q <= PARITY;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bus.sl_start) begin
                        cnt_q   <= '0;
                        shreg_q <= '0;
                        state_q <= SHIFT;
                    end else if (bus.sl_bit_valid) begin
                        if (par_ok) begin
                            out_q   <= shreg_q;
                            wr_q    <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sl_out   = out_q;
    assign bus.sl_wr    = wr_q;
    assign bus.sl_busy  = busy_q;
    assign bus.sl_error = err_q;
endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader at DATA_WIDTH=8.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_serial_loader;
    logic clock;
    logic sl_reset;
    int   checks;
    int   errors;

    serial_loader_if #(.DATA_WIDTH(8)) bus ();

    serial_loader #(.DATA_WIDTH(8)) dut (
        .clock    (clock),
        .sl_reset (sl_reset),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic v, input logic b);
        bus.sl_start     = st;
        bus.sl_bit_valid = v;
        bus.sl_bit       = b;
        @(posedge clock);
        #1;
    endtask

    task automatic outs(input string tag, input logic [7:0] o,
                        input logic w, input logic bz, input logic e);
        chk({tag, ".out"},  32'(bus.sl_out),   32'(o));
        chk({tag, ".wr"},   32'(bus.sl_wr),    32'(w));
        chk({tag, ".busy"}, 32'(bus.sl_busy),  32'(bz));
        chk({tag, ".err"},  32'(bus.sl_error), 32'(e));
    endtask

    task automatic send_bits(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i]);
            chk("busy_bits", 32'(bus.sl_busy), 32'd1);
            chk("wr_bits", 32'(bus.sl_wr), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.sl_start     = 1'b0;
        bus.sl_bit_valid = 1'b0;
        bus.sl_bit       = 1'b0;

        // Reset with noisy inputs
        sl_reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        sl_reset = 1'b0;

        // Idle ignores valid bits
        step(1'b0, 1'b1, 1'b1);
        outs("idle_ign", 8'h00, 1'b0, 1'b0, 1'b0);

        // Good frame 0xA5, parity 0
        step(1'b1, 1'b1, 1'b1);
        outs("a5_start", 8'h00, 1'b0, 1'b1, 1'b0);
        send_bits(8'hA5);
        step(1'b0, 1'b1, 1'b0);
        outs("a5_wr", 8'hA5, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        outs("a5_done", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Bad parity on 0x07
        step(1'b1, 1'b0, 1'b0);
        send_bits(8'h07);
        step(1'b0, 1'b1, 1'b0);
        outs("07_err", 8'hA5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        outs("07_after", 8'hA5, 1'b0, 1'b0, 1'b0);

        // 0x5A with 1..3 idle gaps between bits
        step(1'b1, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'h5A;
            step(1'b0, 1'b1, w[i]);
            chk("5a_busy", 32'(bus.sl_busy), 32'd1);
            for (int g = 0; g <= (i % 3); g++) begin
                step(1'b0, 1'b0, ~w[i]);
                chk("5a_gap_busy", 32'(bus.sl_busy), 32'd1);
                chk("5a_gap_wr", 32'(bus.sl_wr), 32'd0);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        outs("5a_wr", 8'h5A, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        outs("5a_done", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Restart after 3 bits, restart-cycle bit discarded
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        outs("3c_restart", 8'h5A, 1'b0, 1'b1, 1'b0);
        send_bits(8'h3C);
        step(1'b0, 1'b1, 1'b0);
        outs("3c_wr", 8'h3C, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Restart from PARITY state, then 0x81 parity 0
        step(1'b1, 1'b0, 1'b0);
        send_bits(8'hFF);
        step(1'b1, 1'b1, 1'b1);
        outs("par_restart", 8'h3C, 1'b0, 1'b1, 1'b0);
        send_bits(8'h81);
        step(1'b0, 1'b1, 1'b0);
        outs("81_wr", 8'h81, 1'b1, 1'b1, 1'b0);

        // Start during WRITE ignored, next start accepted
        step(1'b1, 1'b1, 1'b1);
        outs("wr_start_ign", 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        outs("b2b_start", 8'h81, 1'b0, 1'b1, 1'b0);
        send_bits(8'h42);
        step(1'b0, 1'b1, 1'b0);
        outs("42_wr", 8'h42, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        outs("42_done", 8'h42, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame, then bits without start
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        sl_reset = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        outs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        sl_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            outs("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        outs("final", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of the assembled word and of sl_out; legal range 2..32.
REQ-002 clock  in  1  single clock; all state updates on posedge clock.
REQ-003 sl_reset  in  1  reset, synchronous, active-high.
REQ-004 sl_start  in  1  begin-frame request, sampled on posedge clock.
REQ-005 sl_bit_valid  in  1  qualifies sl_bit for the current cycle.
REQ-006 sl_bit  in  1  serial data; MSB first, then one even-parity bit.
REQ-007 sl_out  out  DATA_WIDTH  assembled word; feeds the downstream register data input.
REQ-008 sl_wr  out  1  one-cycle write strobe; feeds the downstream register write enable.
REQ-009 sl_busy  out  1  high while a frame is in progress.
REQ-010 sl_error  out  1  one-cycle parity-error pulse.
REQ-011 The block SHALL use one clock, and reset SHALL be synchronous and active-high.

Function
REQ-012 All outputs SHALL be registered; the FSM SHALL have exactly the states IDLE, SHIFT, PARITY and WRITE.
REQ-013 IDLE: sl_start=1 SHALL clear the bit counter and shift register and go to SHIFT; sl_bit_valid in that cycle SHALL be ignored.
REQ-014 IDLE without sl_start: sl_bit_valid SHALL be ignored and the state SHALL hold.
REQ-015 SHIFT: each cycle with sl_bit_valid=1 SHALL shift left, shreg <= {shreg[DATA_WIDTH-2:0], sl_bit}, and increment the counter.
REQ-016 SHIFT: when the valid bit with counter = DATA_WIDTH-1 is accepted, the FSM SHALL go to PARITY; cycles with sl_bit_valid=0 SHALL hold all state.
REQ-017 PARITY: on sl_bit_valid=1, sl_bit == ^shreg SHALL go to WRITE.
REQ-018 PARITY: on sl_bit_valid=1, a mismatch SHALL assert sl_error for exactly the next cycle, return to IDLE, and leave sl_out unchanged.
REQ-019 WRITE: sl_out SHALL equal the assembled shreg, and sl_wr SHALL be 1 for exactly this one cycle.
REQ-020 WRITE SHALL always return to IDLE on the next edge.
REQ-021 Latency: sl_wr SHALL be high in the cycle immediately following the edge that samples a correct parity bit.
REQ-022 sl_out SHALL hold its value between writes.
REQ-023 sl_busy SHALL be 1 in SHIFT, PARITY and WRITE, and 0 in IDLE.
REQ-024 sl_start=1 in SHIFT or PARITY SHALL restart the frame (counter and shreg cleared, state SHIFT); it takes priority over sl_bit_valid, and that cycle's bit SHALL be discarded.
REQ-025 sl_start=1 in WRITE SHALL be ignored; the write SHALL complete.
REQ-026 sl_wr and sl_error SHALL never be high in the same cycle.
REQ-027 The counter SHALL never exceed DATA_WIDTH-1, and there SHALL be no wrap-around into a second word without a new sl_start.

Reset
REQ-028 sl_reset=1 at a posedge SHALL force state IDLE, counter 0, shreg 0, sl_out 0, sl_wr 0, sl_busy 0 and sl_error 0, overriding all other inputs.
REQ-029 Reset mid-frame SHALL discard the partial word, and no sl_wr or sl_error SHALL result from it.

Verification (DATA_WIDTH=8)
REQ-030 Start, then bits 1,0,1,0,0,1,0,1 and parity 0 -> sl_wr for one cycle with sl_out=0xA5, sl_error=0, sl_busy then 0.
REQ-031 After REQ-030, frame 0x07 with parity 0 -> sl_error for one cycle, sl_wr=0, sl_out stays 0xA5.
REQ-032 Frame 0x5A, parity 0, with sl_bit_valid low 1-3 cycles between bits -> sl_busy held high throughout, then sl_out=0x5A with one sl_wr pulse.
REQ-033 Three bits, then sl_start, then frame 0x3C with parity 0 -> sl_out=0x3C; partial bits have no effect.
REQ-034 Reset after 4 bits, then 5 more valid bits without sl_start -> all outputs 0 and no sl_wr.
REQ-035 sl_start in the WRITE cycle is ignored, and sl_start on the next cycle is accepted -> two back-to-back frames produce two sl_wr pulses.
